// File: rtl/adc_seq_pkg.sv
// Shared definitions for the ADC channel sequencer: FSM encoding and default widths.
package adc_seq_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RSP = 2'd2,
    EMIT     = 2'd3
  } seq_state_t;

  localparam int DEF_CHANNEL_W = 5;
  localparam int DEF_DATA_W    = 12;

endpackage

// File: rtl/adc_seq_timeout_counter.sv
// Response watchdog: counts while enabled, restarts on clear, and flags the
// cycle in which the count sits at TIMEOUT_CYCLES-1.
module adc_seq_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic terminal
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign terminal = en && !clr && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Hold at the terminal value; the sequencer leaves WAIT_RSP on that cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !terminal) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/adc_channel_sequencer.sv
// Sweeps a latched list of ADC channel slots over the core's cmd/rsp interface
// and tags each result. Define ADC_SEQ_AVG_EN to average 2^AVG_LOG2 samples per slot.
module adc_channel_sequencer
  import adc_seq_pkg::*;
#(
  parameter int NUM_SLOTS      = 4,
  parameter int CHANNEL_W      = DEF_CHANNEL_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int AVG_LOG2       = 2,
  localparam int NA_W   = $clog2(NUM_SLOTS + 1),
  localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           enable,
  input  logic [NUM_SLOTS*CHANNEL_W-1:0] slot_channels,
  input  logic [NA_W-1:0]                num_active,
  output logic                           cmd_valid,
  output logic [CHANNEL_W-1:0]           cmd_channel,
  input  logic                           cmd_ready,
  input  logic                           rsp_valid,
  input  logic [DATA_W-1:0]              rsp_data,
  output logic                           out_valid,
  output logic [CHANNEL_W-1:0]           out_channel,
  output logic [SLOT_W-1:0]              out_slot,
  output logic [DATA_W-1:0]              out_data,
  output logic                           sweep_done,
  output logic                           timeout_err
);

  seq_state_t                     state_q, state_d;
  logic [SLOT_W-1:0]              slot_q, slot_d;
  logic [NUM_SLOTS*CHANNEL_W-1:0] chans_q, chans_d;
  logic [NA_W-1:0]                nact_q, nact_d;
  logic                           cmd_valid_q, cmd_valid_d;
  logic [CHANNEL_W-1:0]           cmd_channel_q, cmd_channel_d;
  logic                           out_valid_q, out_valid_d;
  logic [CHANNEL_W-1:0]           out_channel_q, out_channel_d;
  logic [SLOT_W-1:0]              out_slot_q, out_slot_d;
  logic [DATA_W-1:0]              out_data_q, out_data_d;
  logic                           sweep_done_q, sweep_done_d;
  logic                           timeout_err_q, timeout_err_d;

  logic            tmo_clr, tmo_en, tmo_hit;
  logic            advance;
  logic            last_slot;
  logic [NA_W-1:0] nact_in;
  logic [NA_W-1:0] slot_inc;

`ifdef ADC_SEQ_AVG_EN
  localparam int ACC_W = DATA_W + AVG_LOG2;
  logic [ACC_W-1:0]    acc_q, acc_d, acc_sum;
  logic [AVG_LOG2-1:0] avg_cnt_q, avg_cnt_d;
`else
  logic unused_avg_cfg;
  assign unused_avg_cfg = ^{1'b0, AVG_LOG2[0]};
`endif

  function automatic logic [NA_W-1:0] clamp_active(input logic [NA_W-1:0] n);
    if (int'(n) > NUM_SLOTS) begin
      return NA_W'(NUM_SLOTS);
    end
    return n;
  endfunction

  function automatic logic [CHANNEL_W-1:0] chan_at(
    input logic [NUM_SLOTS*CHANNEL_W-1:0] list,
    input int                             idx
  );
    return list[idx*CHANNEL_W +: CHANNEL_W];
  endfunction

  assign nact_in   = clamp_active(num_active);
  assign slot_inc  = NA_W'(slot_q) + NA_W'(1);
  assign last_slot = (slot_inc == nact_q);

  adc_seq_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (tmo_clr),
    .en      (tmo_en),
    .terminal(tmo_hit)
  );

  always_comb begin
    state_d       = state_q;
    slot_d        = slot_q;
    chans_d       = chans_q;
    nact_d        = nact_q;
    cmd_valid_d   = 1'b0;
    cmd_channel_d = cmd_channel_q;
    out_valid_d   = 1'b0;
    out_channel_d = out_channel_q;
    out_slot_d    = out_slot_q;
    out_data_d    = out_data_q;
    sweep_done_d  = 1'b0;
    timeout_err_d = 1'b0;
    tmo_clr       = 1'b0;
    tmo_en        = 1'b0;
    advance       = 1'b0;
`ifdef ADC_SEQ_AVG_EN
    acc_d     = acc_q;
    avg_cnt_d = avg_cnt_q;
    acc_sum   = acc_q + ACC_W'(rsp_data);
`endif

    unique case (state_q)
      IDLE: begin
        if (enable && (nact_in != '0)) begin
          chans_d       = slot_channels;
          nact_d        = nact_in;
          slot_d        = '0;
          state_d       = ISSUE;
          cmd_valid_d   = 1'b1;
          cmd_channel_d = chan_at(slot_channels, 0);
        end
      end

      ISSUE: begin
        cmd_valid_d = 1'b1;
        if (cmd_valid_q && cmd_ready) begin
          cmd_valid_d = 1'b0;
          tmo_clr     = 1'b1;
          state_d     = WAIT_RSP;
        end
      end

      WAIT_RSP: begin
        tmo_en = 1'b1;
        if (rsp_valid) begin
`ifdef ADC_SEQ_AVG_EN
          if (avg_cnt_q == '1) begin
            out_valid_d   = 1'b1;
            out_data_d    = DATA_W'(acc_sum >> AVG_LOG2);
            out_channel_d = cmd_channel_q;
            out_slot_d    = slot_q;
            acc_d         = '0;
            avg_cnt_d     = '0;
            state_d       = EMIT;
          end else begin
            // More samples needed for this slot: re-issue the same channel.
            acc_d       = acc_sum;
            avg_cnt_d   = avg_cnt_q + 1'b1;
            cmd_valid_d = 1'b1;
            state_d     = ISSUE;
          end
`else
          out_valid_d   = 1'b1;
          out_data_d    = rsp_data;
          out_channel_d = cmd_channel_q;
          out_slot_d    = slot_q;
          state_d       = EMIT;
`endif
        end else if (tmo_hit) begin
          timeout_err_d = 1'b1;
          advance       = 1'b1;
`ifdef ADC_SEQ_AVG_EN
          acc_d     = '0;
          avg_cnt_d = '0;
`endif
        end
      end

      EMIT: begin
        advance = 1'b1;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Slot boundary, shared by a normal emission and a timed-out slot.
    if (advance) begin
      if (last_slot) begin
        sweep_done_d = 1'b1;
        slot_d       = '0;
        if (enable && (nact_in != '0)) begin
          chans_d       = slot_channels;
          nact_d        = nact_in;
          state_d       = ISSUE;
          cmd_valid_d   = 1'b1;
          cmd_channel_d = chan_at(slot_channels, 0);
        end else begin
          state_d = IDLE;
        end
      end else if (!enable) begin
        slot_d  = '0;
        state_d = IDLE;
      end else begin
        slot_d        = slot_q + 1'b1;
        state_d       = ISSUE;
        cmd_valid_d   = 1'b1;
        cmd_channel_d = chan_at(chans_q, int'(slot_q) + 1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      slot_q        <= '0;
      chans_q       <= '0;
      nact_q        <= '0;
      cmd_valid_q   <= 1'b0;
      cmd_channel_q <= '0;
      out_valid_q   <= 1'b0;
      out_channel_q <= '0;
      out_slot_q    <= '0;
      out_data_q    <= '0;
      sweep_done_q  <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      chans_q       <= chans_d;
      nact_q        <= nact_d;
      cmd_valid_q   <= cmd_valid_d;
      cmd_channel_q <= cmd_channel_d;
      out_valid_q   <= out_valid_d;
      out_channel_q <= out_channel_d;
      out_slot_q    <= out_slot_d;
      out_data_q    <= out_data_d;
      sweep_done_q  <= sweep_done_d;
      timeout_err_q <= timeout_err_d;
    end
  end

`ifdef ADC_SEQ_AVG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      avg_cnt_q <= '0;
    end else begin
      acc_q     <= acc_d;
      avg_cnt_q <= avg_cnt_d;
    end
  end
`endif

  assign cmd_valid   = cmd_valid_q;
  assign cmd_channel = cmd_channel_q;
  assign out_valid   = out_valid_q;
  assign out_channel = out_channel_q;
  assign out_slot    = out_slot_q;
  assign out_data    = out_data_q;
  assign sweep_done  = sweep_done_q;
  assign timeout_err = timeout_err_q;

endmodule
